// File: rtl/ring_lock_sequencer.sv
// Bring-up, lock acquisition and loss-of-lock recovery for one ADPLL ring node.
// Weight bit order is {below, right, above, left}.
module ring_lock_sequencer #(
    parameter int PDET_WIDTH = 5,
    parameter int KP_WIDTH = 6,
    parameter int KI_WIDTH = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter logic [KP_WIDTH-1:0] KP_ACQ = 6'b010010,
    parameter logic [KI_WIDTH-1:0] KI_ACQ = 4'b0010,
    parameter logic [KP_WIDTH-1:0] KP_TRK = 6'b001001,
    parameter logic [KI_WIDTH-1:0] KI_TRK = 4'b0001,
    parameter logic [3:0] PRIMARY_MASK = 4'b0011,
    parameter logic [3:0] NEIGH_MASK = 4'b1100,
    parameter logic [WEIGHT_WIDTH-1:0] WEIGHT_TGT = 4'd2,
    parameter int STARTUP_CYCLES = 1024,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_COUNT = 16,
    parameter int UNLOCK_THRESH = 6,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic                    sample_i,
    input  logic [PDET_WIDTH-1:0]   error_i,
    output logic                    enable_o,
    output logic                    loop_rst_o,
    output logic [KP_WIDTH-1:0]     kp_o,
    output logic [KI_WIDTH-1:0]     ki_o,
    output logic [WEIGHT_WIDTH-1:0] weight_left_o,
    output logic [WEIGHT_WIDTH-1:0] weight_above_o,
    output logic [WEIGHT_WIDTH-1:0] weight_right_o,
    output logic [WEIGHT_WIDTH-1:0] weight_below_o,
    output logic                    locked_o,
    output logic [2:0]              state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STARTUP = 3'd1,
        ACQUIRE = 3'd2,
        COUPLE  = 3'd3,
        TRACK   = 3'd4
    } state_t;

    localparam int SW = $clog2(STARTUP_CYCLES + 1);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYCLES - 1);
    localparam logic [GW-1:0] LOCK_N = GW'(LOCK_COUNT);
    localparam logic [BW-1:0] UNLOCK_N = BW'(UNLOCK_COUNT);
    localparam logic [PDET_WIDTH:0] LOCK_TH = (PDET_WIDTH + 1)'(LOCK_THRESH);
    localparam logic [PDET_WIDTH:0] UNLOCK_TH = (PDET_WIDTH + 1)'(UNLOCK_THRESH);
    // A direction in both masks counts as primary, so it never ramps.
    localparam logic [3:0] RAMP_MASK = NEIGH_MASK & ~PRIMARY_MASK;

    state_t state;
    logic [SW-1:0] cyc_cnt;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    logic [3:0][WEIGHT_WIDTH-1:0] weight;

    logic [PDET_WIDTH:0] err_ext;
    logic [PDET_WIDTH:0] err_mag;
    logic [GW-1:0] good_nxt;
    logic [BW-1:0] bad_nxt;
    logic good_hit;
    logic bad_hit;
    logic ramp_done;
    logic [3:0][WEIGHT_WIDTH-1:0] ramp_w;
    logic [3:0][WEIGHT_WIDTH-1:0] acq_w;

    // One extra bit keeps the magnitude of the most negative error exact.
    assign err_ext = {error_i[PDET_WIDTH-1], error_i};
    assign err_mag = err_ext[PDET_WIDTH] ? (~err_ext + 1'b1) : err_ext;

    always_comb begin
        good_nxt = '0;
        if (err_mag <= LOCK_TH)
            good_nxt = (good_cnt == LOCK_N) ? good_cnt : good_cnt + 1'b1;
        bad_nxt = '0;
        if (err_mag >= UNLOCK_TH)
            bad_nxt = bad_cnt + 1'b1;
    end

    assign good_hit = sample_i && (good_nxt == LOCK_N);
    assign bad_hit = sample_i && (bad_nxt == UNLOCK_N);

    always_comb begin
        ramp_w = weight;
        ramp_done = 1'b1;
        acq_w = '0;
        for (int d = 0; d < 4; d++) begin
            if (PRIMARY_MASK[d])
                acq_w[d] = WEIGHT_TGT;
            if (RAMP_MASK[d]) begin
                if (weight[d] < WEIGHT_TGT)
                    ramp_w[d] = weight[d] + 1'b1;
                if (ramp_w[d] != WEIGHT_TGT)
                    ramp_done = 1'b0;
            end
        end
    end

    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
            cyc_cnt <= '0;
            good_cnt <= '0;
            bad_cnt <= '0;
            weight <= '0;
            enable_o <= 1'b0;
            loop_rst_o <= 1'b1;
            kp_o <= KP_ACQ;
            ki_o <= KI_ACQ;
            locked_o <= 1'b0;
        end else if (stop_i) begin
            state <= IDLE;
            cyc_cnt <= '0;
            good_cnt <= '0;
            bad_cnt <= '0;
            weight <= '0;
            enable_o <= 1'b0;
            loop_rst_o <= 1'b1;
            kp_o <= KP_ACQ;
            ki_o <= KI_ACQ;
            locked_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= STARTUP;
                        cyc_cnt <= '0;
                        enable_o <= 1'b1;
                    end
                end
                STARTUP: begin
                    if (cyc_cnt == START_LAST) begin
                        state <= ACQUIRE;
                        loop_rst_o <= 1'b0;
                        weight <= acq_w;
                        good_cnt <= '0;
                        bad_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (good_hit) begin
                        state <= COUPLE;
                        good_cnt <= '0;
                    end else if (sample_i) begin
                        good_cnt <= good_nxt;
                    end
                end
                COUPLE: begin
                    if (sample_i) begin
                        weight <= ramp_w;
                        if (good_hit && ramp_done) begin
                            state <= TRACK;
                            good_cnt <= '0;
                            bad_cnt <= '0;
                            kp_o <= KP_TRK;
                            ki_o <= KI_TRK;
                            locked_o <= 1'b1;
                        end else begin
                            good_cnt <= good_nxt;
                        end
                    end
                end
                TRACK: begin
                    if (bad_hit) begin
                        state <= ACQUIRE;
                        weight <= acq_w;
                        good_cnt <= '0;
                        bad_cnt <= '0;
                        kp_o <= KP_ACQ;
                        ki_o <= KI_ACQ;
                        locked_o <= 1'b0;
                    end else if (sample_i) begin
                        bad_cnt <= bad_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    cyc_cnt <= '0;
                    good_cnt <= '0;
                    bad_cnt <= '0;
                    weight <= '0;
                    enable_o <= 1'b0;
                    loop_rst_o <= 1'b1;
                    kp_o <= KP_ACQ;
                    ki_o <= KI_ACQ;
                    locked_o <= 1'b0;
                end
            endcase
        end
    end

    assign weight_left_o = weight[0];
    assign weight_above_o = weight[1];
    assign weight_right_o = weight[2];
    assign weight_below_o = weight[3];
    assign state_o = state;

endmodule

// File: tb/tb_ring_lock_sequencer.sv
// Directed plus randomized bench for ring_lock_sequencer with a behavioural model.
module tb_ring_lock_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic stop;
    logic sample;
    logic signed [4:0] err;
    logic enable;
    logic loop_rst;
    logic [5:0] kp;
    logic [3:0] ki;
    logic [3:0] wl;
    logic [3:0] wa;
    logic [3:0] wr;
    logic [3:0] wb;
    logic locked;
    logic [2:0] state;

    ring_lock_sequencer dut (
        .fpga_clk_i(clk),
        .reset_i(rst_n),
        .start_i(start),
        .stop_i(stop),
        .sample_i(sample),
        .error_i(err),
        .enable_o(enable),
        .loop_rst_o(loop_rst),
        .kp_o(kp),
        .ki_o(ki),
        .weight_left_o(wl),
        .weight_above_o(wa),
        .weight_right_o(wr),
        .weight_below_o(wb),
        .locked_o(locked),
        .state_o(state)
    );

    int n_total = 0;
    int n_bad = 0;

    // Model: state number, clocks spent in startup, run lengths, weights [L,A,R,B]
    int m_state;
    int m_clocks;
    int m_good;
    int m_badrun;
    int m_w[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mag(input int e);
        return (e < 0) ? -e : e;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_clocks = 0;
        m_good = 0;
        m_badrun = 0;
        for (int d = 0; d < 4; d++) m_w[d] = 0;
    endtask

    task automatic model_clock();
        int e;
        e = int'(err);
        if (!rst_n || stop) begin
            model_reset();
            return;
        end
        case (m_state)
            0: if (start) begin m_state = 1; m_clocks = 0; end
            1: begin
                m_clocks++;
                if (m_clocks == 1024) begin
                    m_state = 2;
                    m_good = 0;
                    m_w[0] = 2; m_w[1] = 2; m_w[2] = 0; m_w[3] = 0;
                end
            end
            2: if (sample) begin
                m_good = (mag(e) <= 2) ? m_good + 1 : 0;
                if (m_good >= 16) begin m_state = 3; m_good = 0; end
            end
            3: if (sample) begin
                if (m_w[2] < 2) m_w[2]++;
                if (m_w[3] < 2) m_w[3]++;
                m_good = (mag(e) <= 2) ? ((m_good < 16) ? m_good + 1 : 16) : 0;
                if (m_good >= 16 && m_w[2] == 2 && m_w[3] == 2) begin
                    m_state = 4; m_good = 0; m_badrun = 0;
                end
            end
            4: if (sample) begin
                m_badrun = (mag(e) >= 6) ? m_badrun + 1 : 0;
                if (m_badrun == 4) begin
                    m_state = 2; m_w[2] = 0; m_w[3] = 0;
                    m_good = 0; m_badrun = 0;
                end
            end
            default: model_reset();
        endcase
    endtask

    task automatic check_all(input string ph);
        check({ph, ".state"}, state, m_state);
        check({ph, ".enable"}, enable, m_state != 0);
        check({ph, ".loop_rst"}, loop_rst, m_state <= 1);
        check({ph, ".kp"}, kp, (m_state == 4) ? 9 : 18);
        check({ph, ".ki"}, ki, (m_state == 4) ? 1 : 2);
        check({ph, ".locked"}, locked, m_state == 4);
        check({ph, ".wl"}, wl, m_w[0]);
        check({ph, ".wa"}, wa, m_w[1]);
        check({ph, ".wr"}, wr, m_w[2]);
        check({ph, ".wb"}, wb, m_w[3]);
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic samp(input string ph, input int e);
        int gap;
        sample = 1'b1;
        err = 5'(e);
        tick(ph);
        sample = 1'b0;
        gap = int'($urandom_range(0, 2));
        for (int i = 0; i < gap; i++) begin
            err = 5'($urandom_range(0, 31));
            tick(ph);
        end
    endtask

    task automatic small_samp(input string ph);
        samp(ph, int'($urandom_range(0, 4)) - 2);
    endtask

    task automatic run_startup(input string ph);
        int n;
        start = 1'b1;
        tick(ph);
        start = 1'b0;
        n = (state == 3'd1) ? 1 : 0;
        for (int i = 0; i < 2000 && state == 3'd1; i++) begin
            sample = 1'($urandom_range(0, 1));
            err = 5'($urandom_range(0, 31));
            tick(ph);
            if (state == 3'd1) n++;
        end
        sample = 1'b0;
        check({ph, ".startup_len"}, n, 1024);
        check({ph, ".acq_state"}, state, 2);
        check({ph, ".acq_loop_rst"}, loop_rst, 0);
        check({ph, ".acq_wl"}, wl, 2);
        check({ph, ".acq_wa"}, wa, 2);
        check({ph, ".acq_wr"}, wr, 0);
        check({ph, ".acq_wb"}, wb, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        sample = 1'b0;
        err = '0;
        model_reset();
        repeat (2) tick("reset");
        check("reset.state", state, 0);
        check("reset.loop_rst", loop_rst, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick("idle");

        run_startup("boot");

        // 15 good, one bad, then 16 good before COUPLE.
        for (int i = 0; i < 15; i++) small_samp("acq");
        samp("acq", -3);
        check("acq.after_bad", state, 2);
        for (int i = 0; i < 15; i++) small_samp("acq");
        check("acq.fifteen", state, 2);
        small_samp("acq");
        check("acq.to_couple", state, 3);

        samp("cpl", 0);
        check("cpl.wr1", wr, 1);
        check("cpl.wb1", wb, 1);
        samp("cpl", 0);
        check("cpl.wr2", wr, 2);
        for (int i = 0; i < 13; i++) samp("cpl", 0);
        check("cpl.fifteen", state, 3);
        check("cpl.wb_cap", wb, 2);
        samp("cpl", 0);
        check("cpl.to_track", state, 4);
        check("trk.kp", kp, 6'b001001);
        check("trk.ki", ki, 4'b0001);
        check("trk.locked", locked, 1);

        for (int i = 0; i < 3; i++) samp("trk", -16);
        samp("trk", 5);
        check("trk.hold", state, 4);
        for (int i = 0; i < 20; i++) samp("trk", int'($urandom_range(0, 10)) - 5);
        for (int i = 0; i < 4; i++) samp("trk", -16);
        check("unlock.state", state, 2);
        check("unlock.locked", locked, 0);
        check("unlock.wr", wr, 0);
        check("unlock.wb", wb, 0);
        check("unlock.kp", kp, 6'b010010);

        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 19) == 0);
            stop = ($urandom_range(0, 299) == 0);
            sample = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) err = 5'($urandom_range(0, 31));
            else err = 5'(int'($urandom_range(0, 4)) - 2);
            tick("rand");
        end
        start = 1'b0;
        sample = 1'b0;

        stop = 1'b1;
        tick("stop");
        start = 1'b1;
        tick("stop_start");
        check("stop_start.state", state, 0);
        check("stop_start.enable", enable, 0);
        stop = 1'b0;
        start = 1'b0;
        tick("idle2");

        run_startup("boot2");
        for (int i = 0; i < 16; i++) small_samp("acq2");
        samp("cpl2", 0);
        check("cpl2.wr", wr, 1);
        stop = 1'b1;
        tick("cpl_stop");
        stop = 1'b0;
        check("cpl_stop.state", state, 0);
        check("cpl_stop.wl", wl, 0);
        check("cpl_stop.loop_rst", loop_rst, 1);

        run_startup("boot3");
        for (int i = 0; i < 16; i++) small_samp("acq3");
        for (int i = 0; i < 16; i++) small_samp("cpl3");
        check("trk3.state", state, 4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async");
        check("async.locked", locked, 0);
        tick("in_reset");
        rst_n = 1'b1;
        repeat (3) tick("post");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
